hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the single-load-use hazard detector in the in-order RISC-V pipeline. It tracks in-flight loads across a configurable number of load-use bubbles and keeps a per-register scoreboard of pending long-latency results (MUL/DIV, multi-cycle memory). From these it generates the ID-stage stall, a stall cause code and a saturating stall-cycle performance counter. It sits beside the IF/ID and ID/EX registers and drives their enables and the bubble mux.

Parameters:
REG_ADDR_W, 5, register index width.
NUM_REGS, 32, number of architectural registers; must equal 2**REG_ADDR_W.
LOAD_BUBBLES, 1, cycles between load issue and forwardable data; legal range 1..3.
CNT_W, 32, stall-cycle counter width.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
id_valid  in  1  ID stage holds a valid instruction.
id_rs1  in  REG_ADDR_W  source 1 index.
id_rs2  in  REG_ADDR_W  source 2 index.
id_rs1_used  in  1  instruction reads rs1.
id_rs2_used  in  1  instruction reads rs2.
id_rd  in  REG_ADDR_W  destination index.
id_reg_write  in  1  instruction writes rd.
id_mem_read  in  1  instruction is a load.
id_long_op  in  1  instruction is long-latency; result returns via wb_long_*.
flush  in  1  squash the ID instruction this cycle (branch taken in EX).
wb_long_valid  in  1  long-latency result written back this cycle.
wb_long_rd  in  REG_ADDR_W  destination of that result.
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
stall_cause  out  2  00 none, 01 load-use, 10 long RAW, 11 long WAW.
pending_mask  out  NUM_REGS  scoreboard bits; bit i set means register i awaits a long result.
stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (rst_n low, asynchronous): all load-tracker entries invalid, pending_mask=0, stall_cycles=0. stall=0 and stall_cause=00 follow combinationally. This also applies to a reset asserted mid-stall.
- issue = id_valid & ~stall & ~flush.
- Load tracker: shift register of LOAD_BUBBLES entries {valid, rd}. Entry k represents the instruction LOAD_BUBBLES-deep at EX+k. It shifts every cycle and the oldest entry is dropped.
  - Entry 0 loads {1, id_rd} when issue & id_mem_read & id_reg_write & id_rd!=0.
  - Otherwise entry 0 loads {0, x}, including on stall and flush cycles.
- Load-use hazard: any valid entry k whose rd equals id_rs1 with id_rs1_used=1, or equals id_rs2 with id_rs2_used=1.
- Scoreboard, pending bits registered:
  - Bit id_rd sets on issue & id_long_op & id_reg_write & id_rd!=0.
  - Bit wb_long_rd clears on wb_long_valid & wb_long_rd!=0.
  - If set and clear target the same bit in the same cycle, set wins.
  - Bit 0 is always 0.
  - A clear of a non-pending bit is a no-op.
- Long RAW hazard: a used source has its pending bit set. There is no writeback bypass; the stall releases the cycle after the pending bit clears.
- Long WAW hazard: id_reg_write & id_rd!=0 & pending[id_rd]. This keeps writeback in order.
- Source index 0 never causes a hazard.
- Stall and cause:
  - stall = id_valid & ~flush & (load-use | RAW | WAW). Combinational, no added latency.
  - stall_cause priority: load-use > RAW > WAW. Value is 00 when stall=0.
- Flush: stall forced 0; no tracker entry and no pending bit is created for the ID instruction. Older tracker entries and pending bits are unaffected.
- Counter: stall_cycles increments by 1 on each clock edge where stall=1 and holds at 2**CNT_W-1.
- With LOAD_BUBBLES=1 and no long ops, stall equals the classic single-bubble load-use detector.

Test Plan:
1. LOAD_BUBBLES=1: issue lw x5. Next ID add x6,x5,x1 -> stall=1, cause=01 for exactly 1 cycle, then issues; stall_cycles=1.
2. LOAD_BUBBLES=2: lw x5 followed by dependent add -> 2 stall cycles. lw x5, independent instr, then dependent add -> 1 stall cycle.
3. After lw x5: consumer with rs2=x5 and id_rs2_used=0 -> no stall. lw with rd=x0 followed by consumer of x0 -> no stall.
4. Long op rd=x7 issued at cycle t:
   - pending_mask[7]=1 from t+1.
   - Consumer rs1=x7 stalls with cause=10.
   - wb_long_valid with rd=7 at cycle u -> bit clears at u+1, stall drops at u+1.
5. x7 pending, ID instruction writes x7 with no sources used -> cause=11. Load-use and RAW conditions both true in the same cycle -> cause=01.
6. Flush:
   - flush=1 with lw x5 in ID -> stall=0 and no later load-use stall on x5.
   - rst_n low during a RAW stall -> pending_mask=0 and stall=0 immediately.
   - CNT_W=4 with 20 stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: multi-bubble load-use tracking plus a per-register
// scoreboard for long-latency results, with stall cause and stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_long_op,
  input  logic                  flush,
  input  logic                  wb_long_valid,
  input  logic [REG_ADDR_W-1:0] wb_long_rd,
  output logic                  stall,
  output logic [1:0]            stall_cause,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic [LOAD_BUBBLES-1:0] ld_valid;
  logic [REG_ADDR_W-1:0]   ld_rd [LOAD_BUBBLES];
  logic [NUM_REGS-1:0]     pending;
  logic [NUM_REGS-1:0]     pending_next;
  logic [CNT_W-1:0]        cnt;
  logic                    load_use;
  logic                    raw;
  logic                    waw;
  logic                    issue;
  logic                    rs1_live;
  logic                    rs2_live;

  assign rs1_live = id_rs1_used && (id_rs1 != '0);
  assign rs2_live = id_rs2_used && (id_rs2 != '0);

  always_comb begin
    load_use = 1'b0;
    for (int unsigned k = 0; k < LOAD_BUBBLES; k++) begin
      if (ld_valid[k] && ((rs1_live && ld_rd[k] == id_rs1) ||
                          (rs2_live && ld_rd[k] == id_rs2)))
        load_use = 1'b1;
    end
    raw = (rs1_live && pending[id_rs1]) || (rs2_live && pending[id_rs2]);
    waw = id_reg_write && (id_rd != '0) && pending[id_rd];
    stall = id_valid && !flush && (load_use || raw || waw);
    if (!stall)        stall_cause = 2'b00;
    else if (load_use) stall_cause = 2'b01;
    else if (raw)      stall_cause = 2'b10;
    else               stall_cause = 2'b11;
  end

  assign issue = id_valid && !stall && !flush;

  // Entry k holds the load that issued k+1 cycles ago; stall/flush cycles shift in a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid <= '0;
      for (int unsigned k = 0; k < LOAD_BUBBLES; k++) ld_rd[k] <= '0;
    end else begin
      ld_valid[0] <= issue && id_mem_read && id_reg_write && (id_rd != '0);
      ld_rd[0]    <= id_rd;
      for (int unsigned k = 1; k < LOAD_BUBBLES; k++) begin
        ld_valid[k] <= ld_valid[k-1];
        ld_rd[k]    <= ld_rd[k-1];
      end
    end
  end

  // Clear is applied before set so a same-cycle set on the same bit wins.
  always_comb begin
    pending_next = pending;
    if (wb_long_valid && (wb_long_rd != '0))
      pending_next[wb_long_rd] = 1'b0;
    if (issue && id_long_op && id_reg_write && (id_rd != '0))
      pending_next[id_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      pending <= pending_next;
      if (stall && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign pending_mask = pending;
  assign stall_cycles = cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Three configurations (1/2/3 load bubbles, last with a 4-bit counter) driven in
// lockstep and checked against a timestamp-based reference model.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       id_long_op = 1'b0;
  logic       flush = 1'b0;
  logic       wb_long_valid = 1'b0;
  logic [4:0] wb_long_rd = '0;

  logic        st0, st1, st2;
  logic [1:0]  cs0, cs1, cs2;
  logic [31:0] pm0, pm1, pm2;
  logic [31:0] sc0, sc1;
  logic [3:0]  sc2;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_BUBBLES(1), .CNT_W(32)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_long_op(id_long_op),
    .flush(flush), .wb_long_valid(wb_long_valid), .wb_long_rd(wb_long_rd),
    .stall(st0), .stall_cause(cs0), .pending_mask(pm0), .stall_cycles(sc0));

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_BUBBLES(2), .CNT_W(32)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_long_op(id_long_op),
    .flush(flush), .wb_long_valid(wb_long_valid), .wb_long_rd(wb_long_rd),
    .stall(st1), .stall_cause(cs1), .pending_mask(pm1), .stall_cycles(sc1));

  hazard_scoreboard_unit #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_BUBBLES(3), .CNT_W(4)) u_lb3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_long_op(id_long_op),
    .flush(flush), .wb_long_valid(wb_long_valid), .wb_long_rd(wb_long_rd),
    .stall(st2), .stall_cause(cs2), .pending_mask(pm2), .stall_cycles(sc2));

  int vectors = 0;
  int miscompares = 0;

  // Reference state: cycle of the latest issued load per register, pending flags, counters.
  longint cyc = 0;
  longint last_ld [3][32];
  bit     pend [3][32];
  longint cnt [3];
  int     lbv [3] = '{1, 2, 3};
  longint cmax [3] = '{64'd4294967295, 64'd4294967295, 64'd15};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      for (int r = 0; r < 32; r++) begin
        last_ld[i][r] = -100;
        pend[i][r] = 1'b0;
      end
    end
  endfunction

  function automatic bit recent_load(int i, int r);
    return (r != 0) && (last_ld[i][r] < cyc) && (last_ld[i][r] >= cyc - lbv[i]);
  endfunction

  function automatic void model_eval(input int i, output bit st, output logic [1:0] cause);
    bit lu, rw_h, ww_h;
    int r1, r2, d;
    r1 = int'(id_rs1); r2 = int'(id_rs2); d = int'(id_rd);
    lu   = (id_rs1_used && recent_load(i, r1)) || (id_rs2_used && recent_load(i, r2));
    rw_h = (id_rs1_used && r1 != 0 && pend[i][r1]) || (id_rs2_used && r2 != 0 && pend[i][r2]);
    ww_h = id_reg_write && d != 0 && pend[i][d];
    st = id_valid && !flush && (lu || rw_h || ww_h);
    cause = !st ? 2'd0 : lu ? 2'd1 : rw_h ? 2'd2 : 2'd3;
  endfunction

  function automatic void model_step();
    bit st, iss;
    logic [1:0] cause;
    for (int i = 0; i < 3; i++) begin
      model_eval(i, st, cause);
      iss = id_valid && !st && !flush;
      if (st && cnt[i] < cmax[i]) cnt[i]++;
      if (wb_long_valid && wb_long_rd != 0) pend[i][int'(wb_long_rd)] = 1'b0;
      if (iss && id_long_op && id_reg_write && id_rd != 0) pend[i][int'(id_rd)] = 1'b1;
      if (iss && id_mem_read && id_reg_write && id_rd != 0) last_ld[i][int'(id_rd)] = cyc;
    end
    cyc++;
  endfunction

  function automatic logic [31:0] pvec(int i);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = pend[i][r];
    return v;
  endfunction

  task automatic cmp_model();
    bit st;
    logic [1:0] cause;
    logic        ost [3];
    logic [1:0]  ocs [3];
    logic [31:0] opm [3];
    logic [31:0] osc [3];
    ost = '{st0, st1, st2};
    ocs = '{cs0, cs1, cs2};
    opm = '{pm0, pm1, pm2};
    osc = '{sc0, sc1, {28'h0, sc2}};
    for (int i = 0; i < 3; i++) begin
      model_eval(i, st, cause);
      check($sformatf("stall_lb%0d_c%0d", i + 1, cyc), {31'h0, ost[i]}, {31'h0, st});
      check($sformatf("cause_lb%0d_c%0d", i + 1, cyc), {30'h0, ocs[i]}, {30'h0, cause});
      check($sformatf("pending_lb%0d_c%0d", i + 1, cyc), opm[i], pvec(i));
      check($sformatf("count_lb%0d_c%0d", i + 1, cyc), osc[i], cnt[i][31:0]);
    end
  endtask

  // Drive one ID-stage instruction plus writeback port, then compare against the model.
  task automatic apply(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int d, input bit w, input bit m, input bit l, input bit f,
                       input bit wv, input int wr);
    id_valid = v; id_rs1 = r1[4:0]; id_rs1_used = u1; id_rs2 = r2[4:0]; id_rs2_used = u2;
    id_rd = d[4:0]; id_reg_write = w; id_mem_read = m; id_long_op = l; flush = f;
    wb_long_valid = wv; wb_long_rd = wr[4:0];
    #1;
    cmp_model();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_stall", {31'h0, st0}, 32'd0);
    check("reset_pending", pm0, 32'd0);
    tick();

    // lw x5 then add x6,x5,x1 held: 1/2/3 stall cycles per configuration
    apply(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0); tick();
    apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    check("lu1_stall", {31'h0, st0}, 32'd1);
    check("lu1_cause", {30'h0, cs0}, 32'd1);
    tick();
    apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    check("lu1_release", {31'h0, st0}, 32'd0);
    check("lu1_count", sc0, 32'd1);
    check("lu2_second", {31'h0, st1}, 32'd1);
    tick();
    apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    check("lu2_release", {31'h0, st1}, 32'd0);
    check("lu2_count", sc1, 32'd2);
    tick();

    // lw x5, independent, dependent: one stall only for 2 bubbles
    apply(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0, 0); tick();
    apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    check("gap_lb1", {31'h0, st0}, 32'd0);
    check("gap_lb2", {31'h0, st1}, 32'd1);
    tick();
    apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    check("gap_lb2_release", {31'h0, st1}, 32'd0);
    tick();

    // Unused rs2 and x0 destinations never stall
    apply(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 1, 5, 0, 9, 1, 0, 0, 0, 0, 0);
    check("rs2_unused", {31'h0, st0}, 32'd0);
    tick();
    apply(1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0); tick();
    apply(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0);
    check("x0_load", {31'h0, st2}, 32'd0);
    tick();

    // Long op to x7: RAW stall until writeback clears the bit
    apply(1, 1, 1, 0, 0, 7, 1, 0, 1, 0, 0, 0); tick();
    apply(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    check("long_pending", pm0, 32'h80);
    check("raw_cause", {30'h0, cs0}, 32'd2);
    tick();
    apply(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 1, 7);
    check("raw_wb_cycle", {31'h0, st0}, 32'd1);
    tick();
    apply(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    check("raw_release", {31'h0, st0}, 32'd0);
    check("raw_cleared", pm0, 32'h0);
    tick();

    // WAW cause, then load-use beats RAW
    apply(1, 1, 1, 0, 0, 7, 1, 0, 1, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    check("waw_cause", {30'h0, cs0}, 32'd3);
    tick();
    apply(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0); tick();
    apply(1, 5, 1, 7, 1, 10, 1, 0, 0, 0, 0, 0);
    check("lu_over_raw", {30'h0, cs0}, 32'd1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
    repeat (3) idle();

    // Flushed load leaves no tracker entry
    apply(1, 2, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0);
    check("flush_stall", {31'h0, st0}, 32'd0);
    tick();
    apply(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    check("flush_no_lu", {31'h0, st2}, 32'd0);
    tick();

    // Asynchronous reset in the middle of a RAW stall
    apply(1, 1, 1, 0, 0, 7, 1, 0, 1, 0, 0, 0); tick();
    apply(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    check("pre_reset_stall", {31'h0, st0}, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_model();
    check("async_rst_stall", {31'h0, st0}, 32'd0);
    check("async_rst_pending", pm0, 32'd0);
    rst_n = 1'b1;
    #1;
    tick();

    // 20 stall cycles saturate the 4-bit counter
    apply(1, 1, 1, 0, 0, 7, 1, 0, 1, 0, 0, 0); tick();
    repeat (20) begin
      apply(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    check("sat_cnt4", {28'h0, sc2}, 32'd15);
    check("cnt32_twenty", sc0, 32'd20);
    tick();

    // Randomised traffic over a small register window to keep hazards frequent
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      apply($urandom_range(0, 9) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
            int'($urandom_range(0, 7)), kind != 3, kind == 0, kind == 1,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
